// File: rtl/alu_op_issue.sv
// Decode back-end: turns one RV32I instruction plus register operands into an ALU bundle
// and queues it in a small FIFO for execute. Optional macro SHAMT_STRICT_EN rejects odd OP-IMM shift funct7.
module alu_op_issue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inA,
  output logic [XLEN-1:0] out_inB,
  output logic [3:0]      out_ALU_control,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_SLL    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b0110;
  localparam logic [3:0] ALU_XOR    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef SHAMT_STRICT_EN
  localparam logic SHAMT_STRICT = 1'b1;
`else
  localparam logic SHAMT_STRICT = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic            wen;
    logic            ill;
  } entry_t;

  // Shared funct3 -> ALU op map for OP and OP-IMM (base funct7 forms).
  function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic [31:0]     w_imm_i32;
  logic [31:0]     w_imm_s32;
  logic [31:0]     w_imm_u32;

  logic [3:0]      w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_writes;
  logic            w_ill;
  entry_t          w_dec;

  entry_t            r_buf [DEPTH];
  entry_t            r_out;
  logic              r_out_valid;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_accept;
  logic              w_drain;
  logic [PTR_W-1:0]  w_wr_ptr_n;
  logic [PTR_W-1:0]  w_rd_ptr_n;
  logic [CNT_W-1:0]  w_count_n;
  entry_t            w_out_n;

  assign w_opcode  = instr[6:0];
  assign w_funct3  = instr[14:12];
  assign w_funct7  = instr[31:25];
  assign w_rd      = instr[11:7];
  assign w_imm_i32 = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_u32 = {instr[31:12], 12'h000};
  assign w_imm_i   = XLEN'($signed(w_imm_i32));
  assign w_imm_s   = XLEN'($signed(w_imm_s32));
  assign w_imm_u   = XLEN'($signed(w_imm_u32));
  assign w_shamt   = XLEN'(instr[24:20]);

  // Instruction decode into operands, op code and legality.
  always_comb begin
    w_op     = ALU_ADD;
    w_a      = '0;
    w_b      = '0;
    w_writes = 1'b0;
    w_ill    = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_a      = rs1_data;
        w_b      = rs2_data;
        w_writes = 1'b1;
        if (w_funct7 == F7_BASE) begin
          w_op = alu_of_funct3(w_funct3);
        end else if ((w_funct7 == F7_ALT) && (w_funct3 == 3'b000)) begin
          w_op = ALU_SUB;
        end else if ((w_funct7 == F7_ALT) && (w_funct3 == 3'b101)) begin
          w_op = ALU_SRA;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_a      = rs1_data;
        w_writes = 1'b1;
        case (w_funct3)
          3'b001: begin
            w_op = ALU_SLL;
            w_b  = w_shamt;
            if (SHAMT_STRICT && (w_funct7 != F7_BASE)) begin
              w_ill = 1'b1;
            end else begin
              w_ill = 1'b0;
            end
          end
          3'b101: begin
            w_op = instr[30] ? ALU_SRA : ALU_SRL;
            w_b  = w_shamt;
            if (SHAMT_STRICT && (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT)) begin
              w_ill = 1'b1;
            end else begin
              w_ill = 1'b0;
            end
          end
          default: begin
            w_op = alu_of_funct3(w_funct3);
            w_b  = w_imm_i;
          end
        endcase
      end
      OPC_LUI: begin
        w_op     = ALU_PASS_B;
        w_b      = w_imm_u;
        w_writes = 1'b1;
      end
      OPC_AUIPC: begin
        w_a      = pc;
        w_b      = w_imm_u;
        w_writes = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        w_a      = pc;
        w_b      = XLEN'(32'd4);
        w_writes = 1'b1;
      end
      OPC_LOAD: begin
        w_a      = rs1_data;
        w_b      = w_imm_i;
        w_writes = 1'b1;
      end
      OPC_STORE: begin
        w_a = rs1_data;
        w_b = w_imm_s;
      end
      OPC_BRANCH: begin
        w_a = rs1_data;
        w_b = rs2_data;
        case (w_funct3)
          3'b000, 3'b001: w_op  = ALU_SUB;
          3'b100, 3'b101: w_op  = ALU_SLT;
          3'b110, 3'b111: w_op  = ALU_SLTU;
          default:        w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Illegal ops are still queued, but carry a neutral payload.
  always_comb begin
    w_dec    = '0;
    w_dec.rd = w_rd;
    if (w_ill) begin
      w_dec.ill = 1'b1;
    end else begin
      w_dec.a   = w_a;
      w_dec.b   = w_b;
      w_dec.op  = w_op;
      w_dec.wen = w_writes && (w_rd != 5'd0);
    end
  end

  assign in_ready = (r_count < CNT_W'(DEPTH)) && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;

  // Next pointers and occupancy; flush empties the queue regardless of traffic.
  always_comb begin
    w_wr_ptr_n = r_wr_ptr;
    w_rd_ptr_n = r_rd_ptr;
    w_count_n  = r_count;
    if (flush) begin
      w_wr_ptr_n = '0;
      w_rd_ptr_n = '0;
      w_count_n  = '0;
    end else begin
      if (w_accept) begin
        w_wr_ptr_n = r_wr_ptr + PTR_W'(1);
      end else begin
        w_wr_ptr_n = r_wr_ptr;
      end
      if (w_drain) begin
        w_rd_ptr_n = r_rd_ptr + PTR_W'(1);
      end else begin
        w_rd_ptr_n = r_rd_ptr;
      end
      if (w_accept && !w_drain) begin
        w_count_n = r_count + CNT_W'(1);
      end else if (w_drain && !w_accept) begin
        w_count_n = r_count - CNT_W'(1);
      end else begin
        w_count_n = r_count;
      end
    end
  end

  // Next head; a write landing in the new head slot is forwarded so the output stays registered.
  always_comb begin
    w_out_n = r_out;
    if (w_count_n == '0) begin
      w_out_n = r_out;
    end else if (w_accept && (r_wr_ptr == w_rd_ptr_n)) begin
      w_out_n = w_dec;
    end else begin
      w_out_n = r_buf[w_rd_ptr_n];
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= w_dec;
    end
  end

  // Pointers, count and registered head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_count     <= w_count_n;
      r_out_valid <= (w_count_n != '0);
      r_out       <= w_out_n;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_inA         = r_out.a;
  assign out_inB         = r_out.b;
  assign out_ALU_control = r_out.op;
  assign out_rd          = r_out.rd;
  assign out_wen         = r_out.wen;
  assign out_illegal     = r_out.ill;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed vector table, backpressure/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_alu_op_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inA;
  logic [31:0] out_inB;
  logic [3:0]  out_ALU_control;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;

  int checks;
  int failures;

  alu_op_issue #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inA(out_inA), .out_inB(out_inB), .out_ALU_control(out_ALU_control),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  vec_t vecs [15];
  exp_t model_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_head(input string name, input exp_t e);
    check({name, ".valid"}, {63'd0, out_valid}, 64'd1);
    check({name, ".op"}, {60'd0, out_ALU_control}, {60'd0, e.op});
    check({name, ".inA"}, {32'd0, out_inA}, {32'd0, e.a});
    check({name, ".inB"}, {32'd0, out_inB}, {32'd0, e.b});
    check({name, ".wen"}, {63'd0, out_wen}, {63'd0, e.wen});
    check({name, ".illegal"}, {63'd0, out_illegal}, {63'd0, e.ill});
    if (e.wen) check({name, ".rd"}, {59'd0, out_rd}, {59'd0, e.rd});
  endtask

  // Reference decode built from field tables and plain arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                      input logic [31:0] r1, input logic [31:0] r2);
    logic [3:0]  f3tbl [8];
    exp_t        e;
    logic [31:0] immi;
    logic [31:0] imms;
    logic [31:0] immu;
    logic [6:0]  opc;
    logic [6:0]  f7;
    int          f3;
    logic        writes;
    f3tbl = '{4'd0, 4'd4, 4'd8, 4'd9, 4'd7, 4'd5, 4'd3, 4'd2};
    opc  = ins[6:0];
    f7   = ins[31:25];
    f3   = int'(ins[14:12]);
    immi = $signed(ins) >>> 20;
    imms = {immi[31:5], ins[11:7]};
    immu = ins & 32'hFFFF_F000;
    e.rd = ins[11:7]; e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.ill = 1'b0;
    writes = 1'b1;
    if (opc == 7'h33) begin
      e.a = r1; e.b = r2;
      if (f7 == 7'h00) e.op = f3tbl[f3];
      else if (f7 == 7'h20 && f3 == 0) e.op = 4'd1;
      else if (f7 == 7'h20 && f3 == 5) e.op = 4'd6;
      else e.ill = 1'b1;
    end else if (opc == 7'h13) begin
      e.a = r1;
      if (f3 == 1 || f3 == 5) begin
        e.b  = {27'd0, ins[24:20]};
        e.op = (f3 == 1) ? 4'd4 : (ins[30] ? 4'd6 : 4'd5);
`ifdef SHAMT_STRICT_EN
        if (f3 == 1 && f7 != 7'h00) e.ill = 1'b1;
        if (f3 == 5 && f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
`endif
      end else begin
        e.b  = immi;
        e.op = f3tbl[f3];
      end
    end else if (opc == 7'h37) begin
      e.op = 4'd10; e.b = immu;
    end else if (opc == 7'h17) begin
      e.a = pcv; e.b = immu;
    end else if (opc == 7'h6F || opc == 7'h67) begin
      e.a = pcv; e.b = 32'd4;
    end else if (opc == 7'h03) begin
      e.a = r1; e.b = immi;
    end else if (opc == 7'h23) begin
      e.a = r1; e.b = imms; writes = 1'b0;
    end else if (opc == 7'h63) begin
      e.a = r1; e.b = r2; writes = 1'b0;
      if (f3 == 0 || f3 == 1) e.op = 4'd1;
      else if (f3 == 4 || f3 == 5) e.op = 4'd8;
      else if (f3 == 6 || f3 == 7) e.op = 4'd9;
      else e.ill = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.op = 4'd0; e.a = 32'd0; e.b = 32'd0;
    end
    e.wen = writes && !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic exp_t vec_exp(input int i);
    exp_t e;
    e.op = vecs[i].op; e.a = vecs[i].a; e.b = vecs[i].b;
    e.rd = vecs[i].rd; e.wen = vecs[i].wen; e.ill = vecs[i].ill;
    return e;
  endfunction

  task automatic drive_op(input int i);
    in_valid = 1'b1;
    instr    = vecs[i].instr;
    pc       = vecs[i].pc;
    rs1_data = vecs[i].rs1;
    rs2_data = vecs[i].rs2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;

    //           instr          pc            rs1           rs2           op     a             b             rd     wen   ill
    vecs[0]  = '{32'h002081B3, 32'h0000_0100, 32'd5,        32'd7,        4'h0, 32'd5,        32'd7,        5'd3, 1'b1, 1'b0};
    vecs[1]  = '{32'h123452B7, 32'h0000_0104, 32'hDEAD_BEEF,32'h1111_1111,4'hA, 32'd0,        32'h1234_5000,5'd5, 1'b1, 1'b0};
    vecs[2]  = '{32'h40315093, 32'h0000_0108, 32'h8000_0000,32'd9,        4'h6, 32'h8000_0000,32'd3,        5'd1, 1'b1, 1'b0};
    vecs[3]  = '{32'h0020E463, 32'h0000_010C, 32'd11,       32'd22,       4'h9, 32'd11,       32'd22,       5'd8, 1'b0, 1'b0};
    vecs[4]  = '{32'h00100013, 32'h0000_0110, 32'd0,        32'd3,        4'h0, 32'd0,        32'd1,        5'd0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000007F, 32'h0000_0114, 32'h5555_5555,32'hAAAA_AAAA,4'h0, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1};
`ifdef SHAMT_STRICT_EN
    vecs[6]  = '{32'h40511093, 32'h0000_0118, 32'h0000_00F0,32'd0,        4'h0, 32'd0,        32'd0,        5'd1, 1'b0, 1'b1};
`else
    vecs[6]  = '{32'h40511093, 32'h0000_0118, 32'h0000_00F0,32'd0,        4'h4, 32'h0000_00F0,32'd5,        5'd1, 1'b1, 1'b0};
`endif
    vecs[7]  = '{32'h40628233, 32'h0000_011C, 32'd100,      32'd42,       4'h1, 32'd100,      32'd42,       5'd4, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFFFF397, 32'h0000_1000, 32'd1,        32'd2,        4'h0, 32'h0000_1000,32'hFFFF_F000,5'd7, 1'b1, 1'b0};
    vecs[9]  = '{32'h008000EF, 32'h0000_2000, 32'd1,        32'd2,        4'h0, 32'h0000_2000,32'd4,        5'd1, 1'b1, 1'b0};
    vecs[10] = '{32'h0020A623, 32'h0000_2004, 32'h0000_4000,32'd2,        4'h0, 32'h0000_4000,32'd12,       5'd12,1'b0, 1'b0};
    vecs[11] = '{32'hFFC0A183, 32'h0000_2008, 32'h0000_4000,32'd2,        4'h0, 32'h0000_4000,32'hFFFF_FFFC,5'd3, 1'b1, 1'b0};
    vecs[12] = '{32'h0020A463, 32'h0000_200C, 32'd7,        32'd8,        4'h0, 32'd0,        32'd0,        5'd8, 1'b0, 1'b1};
    vecs[13] = '{32'h022081B3, 32'h0000_2010, 32'd7,        32'd8,        4'h0, 32'd0,        32'd0,        5'd3, 1'b0, 1'b1};
    vecs[14] = '{32'h402091B3, 32'h0000_2014, 32'd7,        32'd8,        4'h0, 32'd0,        32'd0,        5'd3, 1'b0, 1'b1};

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.inA", {32'd0, out_inA}, 64'd0);
    check("rst.inB", {32'd0, out_inB}, 64'd0);
    check("rst.op", {60'd0, out_ALU_control}, 64'd0);
    check("rst.rd", {59'd0, out_rd}, 64'd0);
    check("rst.wen_ill", {62'd0, out_wen, out_illegal}, 64'd0);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);
    next_cycle();

    // Directed vectors, one at a time through an empty buffer
    for (int i = 0; i < 15; i++) begin
      drive_op(i);
      out_ready = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d.in_ready", i), {63'd0, in_ready}, 64'd1);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check_head($sformatf("vec%0d", i), vec_exp(i));
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d.drained", i), {63'd0, out_valid}, 64'd0);
      next_cycle();
    end

    // Backpressure: three back-to-back ops with the consumer stalled
    out_ready = 1'b0;
    drive_op(0);
    @(negedge clk);
    check("bp.ready0", {63'd0, in_ready}, 64'd1);
    next_cycle();
    drive_op(1);
    @(negedge clk);
    check("bp.ready1", {63'd0, in_ready}, 64'd1);
    check_head("bp.headA0", vec_exp(0));
    next_cycle();
    drive_op(2);
    @(negedge clk);
    check("bp.ready2_full", {63'd0, in_ready}, 64'd0);
    next_cycle();
    @(negedge clk);
    check("bp.still_full", {63'd0, in_ready}, 64'd0);
    check_head("bp.headA_stable", vec_exp(0));
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.full_drain_ready", {63'd0, in_ready}, 64'd0);
    check_head("bp.headA", vec_exp(0));
    next_cycle();
    @(negedge clk);
    check("bp.ready_after_drop", {63'd0, in_ready}, 64'd1);
    check_head("bp.headB", vec_exp(1));
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check_head("bp.headC", vec_exp(2));
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp.empty", {63'd0, out_valid}, 64'd0);
    next_cycle();

    // Flush with two buffered entries and a competing input
    drive_op(3);
    next_cycle();
    drive_op(4);
    next_cycle();
    drive_op(5);
    flush = 1'b1;
    @(negedge clk);
    check("fl.ready_during", {63'd0, in_ready}, 64'd0);
    check("fl.valid_before", {63'd0, out_valid}, 64'd1);
    next_cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("fl.valid_after", {63'd0, out_valid}, 64'd0);
    check("fl.ready_after", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("fl.stays_empty%0d", k), {63'd0, out_valid}, 64'd0);
    end
    next_cycle();
    out_ready = 1'b0;

    // Reset mid-operation, together with flush
    drive_op(1);
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    flush = 1'b1;
    next_cycle();
    rst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("mr.out_valid", {63'd0, out_valid}, 64'd0);
    check("mr.inB", {32'd0, out_inB}, 64'd0);
    check("mr.op", {60'd0, out_ALU_control}, 64'd0);
    check("mr.in_ready", {63'd0, in_ready}, 64'd1);
    next_cycle();

    // Randomized traffic against the queue model
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [6:0]  opcs [10];
      logic [31:0] r;
      int          k;
      logic        exp_ready;
      logic        exp_valid;
      exp_t        e;
      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13};
      r = $urandom;
      k = $urandom_range(0, 10);
      if (k < 10) r[6:0] = opcs[k];
      if (r[6:0] == 7'h33 && r[0 +: 1] == 1'b1 && $urandom_range(0, 3) != 0)
        r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      instr     = r;
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      exp_ready = (model_q.size() < 2) && !flush;
      exp_valid = (model_q.size() != 0);
      check("rnd.in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      check("rnd.out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      if (exp_valid) check_head("rnd.head", model_q[0]);
      if (flush) begin
        model_q.delete();
      end else begin
        if (exp_valid && out_ready) void'(model_q.pop_front());
        if (in_valid && exp_ready) begin
          e = ref_decode(instr, pc, rs1_data, rs2_data);
          model_q.push_back(e);
        end
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Decode stage back-end that produces ALU operation bundles: `ALU_control`, `inA`, `inB` and destination info, in the 4-bit ALU operation encoding below.
- Decodes one RV32I instruction plus register-file operands per handshake.
- Registers each bundle into a 2-entry issue buffer and presents it to the execute stage over valid/ready, with flush support.
- Sits between register read and the ALU in the RiSC-V core.

Parameters:
- XLEN, 32, operand/result width
- DEPTH, 2, issue buffer entries (power of two, at least 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all buffered and incoming ops (branch redirect)
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  buffer can accept this cycle
- instr  input  32  RV32I instruction word
- pc  input  XLEN  instruction address
- rs1_data  input  XLEN  register-file read port 1
- rs2_data  input  XLEN  register-file read port 2
- out_valid  output  1  head entry valid
- out_ready  input  1  execute stage consumes head
- out_inA  output  XLEN  ALU operand A
- out_inB  output  XLEN  ALU operand B
- out_ALU_control  output  4  ALU op code
- out_rd  output  5  destination register
- out_wen  output  1  register writeback enable (0 if rd==0)
- out_illegal  output  1  instruction not decodable

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SRL, 0110 SRA, 0111 XOR
  - 1000 SLT, 1001 SLTU, 1010 PASS_B
  - 1011-1111 never emitted
- OP (0110011): A=rs1, B=rs2.
  - funct3/funct7 map: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND.
  - Any other funct7 is illegal.
- OP-IMM (0010011): A=rs1, B=sign-extended imm[11:0]; same funct3 map, no SUBI.
  - Shifts use B={27'b0,shamt}.
  - funct3 101 with imm[10]=1 gives SRA.
- LUI: A=0, B={imm[31:12],12'b0}, PASS_B.
- AUIPC: A=pc, B={imm[31:12],12'b0}, ADD.
- JAL/JALR: A=pc, B=4, ADD.
- LOAD: A=rs1, B=sext I-imm, ADD.
- STORE: A=rs1, B=sext S-imm, ADD; out_wen=0.
- BRANCH: A=rs1, B=rs2; out_wen=0.
  - BEQ/BNE SUB; BLT/BGE SLT; BLTU/BGEU SLTU.
  - funct3 010/011 illegal.
- Illegal (any other opcode or invalid funct): entry still enqueued with out_illegal=1, ALU_control=0000, A=B=0, out_wen=0.
- Handshake:
  - Transfer occurs when valid && ready.
  - Decode is combinational on input; result written into buffer on accept.
  - Latency: accept at cycle N, out_valid=1 at cycle N+1 if buffer was empty.
- in_ready = (count < DEPTH) && !flush. It depends only on registered count and flush, never on out_ready.
- Simultaneous accept and drain when full is not allowed (in_ready=0). When 0<count<DEPTH, simultaneous accept and drain keeps count unchanged.
- Ordering: strict FIFO; head outputs stay stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH; count range is 0..DEPTH.
- Empty: out_valid=0. Output data fields are don't-care but held at their last value.
- flush:
  - Next cycle count=0 and out_valid=0.
  - An input presented during flush is not accepted.
  - A drain in the same cycle is still considered consumed by the receiver.
- Reset: count=0, pointers=0, out_valid=0, out_inA=0, out_inB=0, out_ALU_control=0, out_rd=0, out_wen=0, out_illegal=0. Reset mid-operation discards all entries and overrides flush.

Optional Feature:
- SHAMT_STRICT_EN defined: OP-IMM shifts with instr[31:25] other than 0000000 (SLLI/SRLI) or 0100000 (SRAI) are flagged out_illegal=1.
- Undefined: those bits beyond imm[10] are ignored and the shift is decoded normally.

Test Plan:
- ADD x3,x1,x2 (instr 0x002081B3), rs1=5, rs2=7, buffer empty → next cycle out_valid=1, ALU_control=0000, inA=5, inB=7, rd=3, wen=1.
- LUI x5,0x12345 (0x123452B7) → ALU_control=1010, inA=0, inB=0x12345000, wen=1. SRAI x1,x2,3 (0x40315093) → ALU_control=0110, inB=3.
- BLTU x1,x2,off → ALU_control=1001, wen=0. ADDI x0,x0,1 → wen=0.
- Hold out_ready=0 and present 3 back-to-back ops → first two accepted, in_ready=0 on third. Release out_ready → ops emerge in order, third accepted the cycle after count drops.
- With 2 entries buffered, assert flush alongside in_valid → next cycle out_valid=0, in_ready=1. Flushed op never appears.
- instr 0x0000007F → out_illegal=1, ALU_control=0000, wen=0. SLLI with instr[31:25]=0100000: out_illegal=1 with SHAMT_STRICT_EN, 0 without.
